// File: rtl/itof_pipe.sv
`default_nettype none
// ============================================================================
// Module   : itof_pipe
// Purpose  : Three-stage signed int32 -> IEEE-754 single converter, RNE
//            rounding, valid/ready handshake, whole-pipe stall on backpressure.
//            Optional `inexact` output enabled by defining ITOF_INEXACT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module itof_pipe (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] src,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dest
`ifdef ITOF_INEXACT_EN
    ,
    output logic        inexact
`endif
);

    logic        w_stall;
    logic        w_adv;

    logic        r_s1_valid;
    logic        r_s1_sign;
    logic [31:0] r_s1_mag;

    logic [4:0]  w_lead_pos;
    logic [31:0] w_norm;

    logic        r_s2_valid;
    logic        r_s2_sign;
    logic        r_s2_zero;
    logic [4:0]  r_s2_pos;
    logic [30:0] r_s2_norm;

    logic [22:0] w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic        w_carry;
    logic [22:0] w_mant_rnd;
    logic [7:0]  w_exp;
    logic [31:0] w_result;

    logic        r_out_valid;
    logic [31:0] r_dest;

    assign w_stall  = r_out_valid & ~out_ready;
    assign w_adv    = ~w_stall;
    assign in_ready = w_adv;

    // Stage 1: sign and magnitude; -2^31 negates to itself, which is the
    // correct unsigned magnitude 0x80000000.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_mag   <= 32'd0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_sign  <= src[31];
            r_s1_mag   <= src[31] ? (~src + 32'd1) : src;
        end
    end

    always_comb begin
        w_lead_pos = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (r_s1_mag[i]) begin
                w_lead_pos = 5'(i);
            end
        end
    end

    assign w_norm = r_s1_mag << (5'd31 - w_lead_pos);

    // Stage 2: a nonzero magnitude always normalises to bit 31 set, so that
    // bit doubles as the not-zero flag and is not carried further.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_zero  <= 1'b1;
            r_s2_pos   <= 5'd0;
            r_s2_norm  <= 31'd0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_zero  <= ~w_norm[31];
            r_s2_pos   <= w_lead_pos;
            r_s2_norm  <= w_norm[30:0];
        end
    end

    // Small magnitudes shift zeros into the guard/sticky field, so the
    // exact case needs no special handling.
    assign w_mant     = r_s2_norm[30:8];
    assign w_guard    = r_s2_norm[7];
    assign w_sticky   = |r_s2_norm[6:0];
    assign w_round_up = w_guard & (w_sticky | w_mant[0]);
    assign {w_carry, w_mant_rnd} = {1'b0, w_mant} + {23'd0, w_round_up};
    assign w_exp      = 8'd127 + {3'd0, r_s2_pos} + {7'd0, w_carry};
    assign w_result   = r_s2_zero ? 32'd0 : {r_s2_sign, w_exp, w_mant_rnd};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_dest      <= 32'd0;
        end else if (w_adv) begin
            r_out_valid <= r_s2_valid;
            r_dest      <= w_result;
        end
    end

    assign out_valid = r_out_valid;
    assign dest      = r_dest;

`ifdef ITOF_INEXACT_EN
    logic r_inexact;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inexact <= 1'b0;
        end else if (w_adv) begin
            r_inexact <= w_guard | w_sticky;
        end
    end

    assign inexact = r_inexact;
`endif

endmodule
`default_nettype wire

// File: tb/tb_itof_pipe.sv
`default_nettype none
// Testbench for itof_pipe: directed vectors, backpressure, mid-flight reset
// and a randomised-handshake sweep, checked through an in-order scoreboard.
module tb_itof_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] src = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] dest;
`ifdef ITOF_INEXACT_EN
    logic        inexact;
`endif

    itof_pipe dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src       (src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dest      (dest)
`ifdef ITOF_INEXACT_EN
        ,
        .inexact   (inexact)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        x;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] drv_d = 32'd0;
    logic        drv_x = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dest = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // Independent reference: exact double conversion, then RNE down to 23 bits.
    function automatic exp_t model(input logic [31:0] s);
        exp_t        r;
        logic [63:0] b;
        logic [22:0] keep;
        logic [28:0] rest;
        logic [23:0] sum;
        int          e;
        if (s == 32'd0) begin
            r.d = 32'd0;
            r.x = 1'b0;
            return r;
        end
        b    = $realtobits($itor($signed(s)));
        keep = b[51:29];
        rest = b[28:0];
        sum  = {1'b0, keep} + {23'd0, rest[28] & ((|rest[27:0]) | keep[0])};
        e    = int'(b[62:52]) - 1023 + 127 + int'(sum[23]);
        r.d  = {b[63], e[7:0], sum[22:0]};
        r.x  = |rest;
        return r;
    endfunction

    // Scoreboard: push on accept, pop and compare on output transfer.
    always @(posedge clk) begin
        if (rstn) begin
            if (in_valid && in_ready) begin
                exp_q.push_back({drv_d, drv_x});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, required no output", dest);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("dest", dest, e.d);
`ifdef ITOF_INEXACT_EN
                    check("inexact", {31'd0, inexact}, {31'd0, e.x});
`endif
                end
            end
        end
    end

    // Handshake rule and output hold while stalled.
    always @(negedge clk) begin
        if (rstn) begin
            check("in_ready_rule", {31'd0, in_ready}, {31'd0, ~(out_valid & ~out_ready)});
            if (prev_stall) begin
                check("hold_dest", dest, prev_dest);
                check("hold_valid", {31'd0, out_valid}, 32'd1);
            end
            prev_stall <= out_valid & ~out_ready;
            prev_dest  <= dest;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v, input logic [31:0] ed, input logic ex);
        logic acc;
        int   t;
        in_valid = 1'b1;
        src      = v;
        drv_d    = ed;
        drv_x    = ex;
        t        = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) break;
            t++;
            if (t > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: got in_ready 0, required 1 within 200 cycles");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            tick();
            t++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    logic [31:0] dir_src [0:12] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h80000000,
                                    32'h7FFFFFFF, 32'h01000001, 32'h01000003, 32'hFEFFFFFD,
                                    32'h00000002, 32'h00000003, 32'h00000064, 32'h01000000,
                                    32'h01000002};
    logic [31:0] dir_exp [0:12] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'hCF000000,
                                    32'h4F000000, 32'h4B800000, 32'h4B800002, 32'hCB800002,
                                    32'h40000000, 32'h40400000, 32'h42C80000, 32'h4B800000,
                                    32'h4B800001};
    logic        dir_x   [0:12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] bp_exp  [0:9]  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                                    32'h41100000, 32'h41200000};

    initial begin
        bit done;
        repeat (3) tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_dest", dest, 32'd0);
`ifdef ITOF_INEXACT_EN
        check("rst_inexact", {31'd0, inexact}, 32'd0);
`endif
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            send(dir_src[i], dir_exp[i], dir_x[i]);
        end
        drain();

        // Backpressure: ten back-to-back operands, out_ready low for cycles 4..7.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(32'(i + 1), bp_exp[i], 1'b0);
                end
                done = 1'b1;
            end
            begin
                for (int c = 0; !done && c < 100; c++) begin
                    out_ready = !(c >= 4 && c <= 7);
                    tick();
                end
            end
        join
        drain();

        // Reset mid-flight: three operands held in the pipe by backpressure.
        out_ready = 1'b0;
        send(32'd4, 32'h40800000, 1'b0);
        send(32'd5, 32'h40A00000, 1'b0);
        send(32'd6, 32'h40C00000, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        #3;
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_no_output", {31'd0, out_valid}, 32'd0);
        end
        send(32'd7, 32'h40E00000, 1'b0);
        drain();

        // Randomised sweep with random gaps and random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3000; i++) begin
                    logic [31:0] v;
                    exp_t        e;
                    v = $urandom >> $urandom_range(0, 31);
                    if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
                    if (i % 97 == 0) v = 32'h80000000;
                    e = model(v);
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) tick();
                    end
                    send(v, e.d, e.x);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 9) < 7);
                    tick();
                end
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
